// File: rtl/siso_pkg.sv
// rtl/siso_pkg.sv - shared constants for the serial-in serial-out right shifter
package siso_pkg;

    localparam int   SISO_WIDTH_DEFAULT = 4;
    localparam logic SISO_RST_VAL       = 1'b0;

endpackage : siso_pkg

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - single shift-register stage: D flop with async active-low clear
module shift_stage
    import siso_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= SISO_RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule : shift_stage

// File: rtl/siso_4bit_rshift.sv
// rtl/siso_4bit_rshift.sv - WIDTH-stage SISO right shifter; SISO_RSHIFT_PAR_OUT_EN adds parallel q_o
module siso_4bit_rshift
    import siso_pkg::*;
#(
    parameter int WIDTH = SISO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i,
    output logic             f
`ifdef SISO_RSHIFT_PAR_OUT_EN
    ,
    output logic [WIDTH-1:0] q_o
`endif
);

    logic [WIDTH-1:0] q;

    // New bits enter the MSB stage and walk down towards stage 0, which feeds f.
    for (genvar k = 0; k < WIDTH; k++) begin : g_stage
        logic d;
        if (k == WIDTH - 1) begin : g_head
            assign d = i;
        end else begin : g_link
            assign d = q[k+1];
        end
        shift_stage u_stage (
            .clk (clk),
            .rst (rst),
            .d   (d),
            .q   (q[k])
        );
    end

    assign f = q[0];

`ifdef SISO_RSHIFT_PAR_OUT_EN
    assign q_o = q;
`endif

endmodule : siso_4bit_rshift

// File: tb/tb_siso_4bit_rshift.sv
// tb/tb_siso_4bit_rshift.sv - self-checking bench for siso_4bit_rshift (WIDTH 4 and 8)
module tb_siso_4bit_rshift;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i4  = 1'b0;
    logic i8  = 1'b0;
    logic f4;
    logic f8;
`ifdef SISO_RSHIFT_PAR_OUT_EN
    logic [3:0] qo4;
    logic [7:0] qo8;
`endif

    int tests = 0;
    int fails = 0;

    logic sb4[$];
    logic sb8[$];

    always #5 clk = ~clk;

    siso_4bit_rshift #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .i   (i4),
        .f   (f4)
`ifdef SISO_RSHIFT_PAR_OUT_EN
        ,
        .q_o (qo4)
`endif
    );

    siso_4bit_rshift #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .i   (i8),
        .f   (f8)
`ifdef SISO_RSHIFT_PAR_OUT_EN
        ,
        .q_o (qo8)
`endif
    );

    // After reset the register holds zeros, so WIDTH-1 zero bits leave before the first new one.
    task automatic sb_clear();
        sb4.delete();
        sb8.delete();
        repeat (3) sb4.push_back(1'b0);
        repeat (7) sb8.push_back(1'b0);
    endtask

    task automatic tick(input logic b4, input logic b8);
        i4 = b4;
        i8 = b8;
        sb4.push_back(b4);
        sb8.push_back(b8);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        sb_clear();
    endtask

    task automatic test_reset();
        logic e4;
        logic e8;
        rst = 1'b0;
        i4  = 1'b1;
        i8  = 1'b1;
        #1;
        tests++;
        if (f4 !== 1'b0 || f8 !== 1'b0) begin
            fails++;
            $display("FAIL reset_initial: f4=%b f8=%b expected 0 0", f4, f8);
        end
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            e4 = 1'b0;
            e8 = 1'b0;
            tests++;
            if (f4 !== e4 || f8 !== e8) begin
                fails++;
                $display("FAIL reset_hold cycle %0d: f4=%b f8=%b expected %b %b", c, f4, f8, e4, e8);
            end
`ifdef SISO_RSHIFT_PAR_OUT_EN
            tests++;
            if (qo4 !== 4'b0000 || qo8 !== 8'h00) begin
                fails++;
                $display("FAIL reset_qo cycle %0d: qo4=%b qo8=%b expected 0", c, qo4, qo8);
            end
`endif
        end
    endtask

    task automatic test_stream();
        logic stim [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic fexp [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic e4;
        logic e8;
        rst = 1'b1;
        sb_clear();
        for (int e = 1; e <= 7; e++) begin
            tick(stim[e-1], stim[e-1]);
            e4 = sb4.pop_front();
            e8 = sb8.pop_front();
            tests++;
            if (f4 !== e4 || f4 !== fexp[e-1]) begin
                fails++;
                $display("FAIL stream edge %0d: f4=%b expected %b", e, f4, fexp[e-1]);
            end
            tests++;
            if (f8 !== e8) begin
                fails++;
                $display("FAIL stream8 edge %0d: f8=%b expected %b", e, f8, e8);
            end
`ifdef SISO_RSHIFT_PAR_OUT_EN
            if (e == 4) begin
                tests++;
                if (qo4 !== 4'b0110) begin
                    fails++;
                    $display("FAIL stream_qo edge 4: qo4=%b expected 0110", qo4);
                end
            end
`endif
        end
    endtask

    task automatic test_single_pulse();
        logic e4;
        logic e8;
        apply_reset();
        for (int e = 1; e <= 10; e++) begin
            tick(e == 1, e == 1);
            e4 = sb4.pop_front();
            e8 = sb8.pop_front();
            tests++;
            if (f4 !== e4 || f4 !== (e == 4)) begin
                fails++;
                $display("FAIL pulse edge %0d: f4=%b expected %b", e, f4, e == 4);
            end
            tests++;
            if (f8 !== e8 || f8 !== (e == 8)) begin
                fails++;
                $display("FAIL pulse8 edge %0d: f8=%b expected %b", e, f8, e == 8);
            end
        end
    endtask

    task automatic test_fill();
        logic e4;
        logic e8;
        apply_reset();
        for (int e = 1; e <= 8; e++) begin
            tick(1'b1, 1'b1);
            e4 = sb4.pop_front();
            e8 = sb8.pop_front();
            tests++;
            if (f4 !== e4 || f4 !== (e >= 4)) begin
                fails++;
                $display("FAIL fill edge %0d: f4=%b expected %b", e, f4, e >= 4);
            end
            tests++;
            if (f8 !== e8 || f8 !== (e >= 8)) begin
                fails++;
                $display("FAIL fill8 edge %0d: f8=%b expected %b", e, f8, e >= 8);
            end
`ifdef SISO_RSHIFT_PAR_OUT_EN
            if (e == 4) begin
                tests++;
                if (qo4 !== 4'b1111) begin
                    fails++;
                    $display("FAIL fill_qo edge 4: qo4=%b expected 1111", qo4);
                end
            end
`endif
        end
    endtask

    task automatic test_midstream_reset();
        logic e4;
        logic e8;
        #2 rst = 1'b0;
        i4 = 1'b0;
        i8 = 1'b0;
        #1;
        tests++;
        if (f4 !== 1'b0 || f8 !== 1'b0) begin
            fails++;
            $display("FAIL midreset_async: f4=%b f8=%b expected 0 0", f4, f8);
        end
`ifdef SISO_RSHIFT_PAR_OUT_EN
        tests++;
        if (qo4 !== 4'b0000 || qo8 !== 8'h00) begin
            fails++;
            $display("FAIL midreset_qo: qo4=%b qo8=%b expected 0", qo4, qo8);
        end
`endif
        #1 rst = 1'b1;
        sb_clear();
        for (int e = 1; e <= 8; e++) begin
            tick(1'b0, 1'b0);
            e4 = sb4.pop_front();
            e8 = sb8.pop_front();
            tests++;
            if (f4 !== e4 || f4 !== 1'b0 || f8 !== e8 || f8 !== 1'b0) begin
                fails++;
                $display("FAIL midreset_drain edge %0d: f4=%b f8=%b expected 0 0", e, f4, f8);
            end
        end
    endtask

    task automatic test_x_propagation();
        logic e4;
        logic e8;
        apply_reset();
        for (int e = 1; e <= 8; e++) begin
            tick((e == 1) ? 1'bx : 1'b0, (e == 1) ? 1'bx : 1'b0);
            e4 = sb4.pop_front();
            e8 = sb8.pop_front();
            tests++;
            if (f4 !== e4 || f8 !== e8) begin
                fails++;
                $display("FAIL xprop edge %0d: f4=%b f8=%b expected %b %b", e, f4, f8, e4, e8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_single_pulse();
        test_fill();
        test_midstream_reset();
        test_x_propagation();
        if (sb4.size() != 3 || sb8.size() != 7) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_depth: sb4=%0d sb8=%0d expected 3 7", sb4.size(), sb8.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_siso_4bit_rshift
